// File: rtl/regfile_pkg.sv
// Types and constants shared by the read and write sides of the 32x64 register file.
package regfile_pkg;

  localparam int WIDTH = 64;
  localparam int NREGS = 32;

  typedef logic [4:0]  reg_idx_t;
  typedef logic [63:0] word_t;

  localparam reg_idx_t ZERO_REG = 5'd31;

endpackage

// File: rtl/regfile_read_port_mux.sv
// One-bit 2:1 mux cell and the 32:1 mux tree built from it.
module mux2_1 (
  input  logic a_i,
  input  logic b_i,
  input  logic sel_i,
  output logic y_o
);
  assign y_o = sel_i ? b_i : a_i;
endmodule

module mux32_1 (
  input  logic [31:0] in_i,
  input  logic [4:0]  sel_i,
  output logic        out_o
);
  logic [15:0] l4;
  logic [7:0]  l3;
  logic [3:0]  l2;
  logic [1:0]  l1;

  // Each tree level consumes one select bit, LSB at the leaves.
  for (genvar i = 0; i < 16; i++) begin : g_l4
    mux2_1 u_mux (.a_i(in_i[2*i]), .b_i(in_i[2*i+1]), .sel_i(sel_i[0]), .y_o(l4[i]));
  end
  for (genvar i = 0; i < 8; i++) begin : g_l3
    mux2_1 u_mux (.a_i(l4[2*i]), .b_i(l4[2*i+1]), .sel_i(sel_i[1]), .y_o(l3[i]));
  end
  for (genvar i = 0; i < 4; i++) begin : g_l2
    mux2_1 u_mux (.a_i(l3[2*i]), .b_i(l3[2*i+1]), .sel_i(sel_i[2]), .y_o(l2[i]));
  end
  for (genvar i = 0; i < 2; i++) begin : g_l1
    mux2_1 u_mux (.a_i(l2[2*i]), .b_i(l2[2*i+1]), .sel_i(sel_i[3]), .y_o(l1[i]));
  end
  mux2_1 u_root (.a_i(l1[0]), .b_i(l1[1]), .sel_i(sel_i[4]), .y_o(out_o));
endmodule

// File: rtl/regfile_read_port.sv
// Dual read port with write bypass, X31 zero override and a stallable/flushable output register.
module regfile_read_port
  import regfile_pkg::*;
#(
  parameter int WIDTH = regfile_pkg::WIDTH,
  parameter int NREGS = regfile_pkg::NREGS
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NREGS-1:0][WIDTH-1:0] RegValues,
  input  reg_idx_t                    ReadRegister1,
  input  reg_idx_t                    ReadRegister2,
  input  logic                        ValidIn,
  input  logic                        RegWrite,
  input  reg_idx_t                    WriteRegister,
  input  logic [WIDTH-1:0]            WriteData,
  input  logic                        Stall,
  input  logic                        Flush,
  output logic [WIDTH-1:0]            ReadData1,
  output logic [WIDTH-1:0]            ReadData2,
  output reg_idx_t                    ReadReg1Q,
  output reg_idx_t                    ReadReg2Q,
  output logic                        ValidOut
);

  logic [WIDTH-1:0][NREGS-1:0] col;
  logic [WIDTH-1:0]            raw1, raw2;
  logic [WIDTH-1:0]            nxt1, nxt2;
  logic                        byp1, byp2;

  logic [WIDTH-1:0] rd1_d, rd1_q, rd2_d, rd2_q;
  reg_idx_t         idx1_d, idx1_q, idx2_d, idx2_q;
  logic             vld_d, vld_q;

  // Bit-slice transpose: each mux tree sees one bit of every register.
  for (genvar k = 0; k < WIDTH; k++) begin : g_bit
    for (genvar r = 0; r < NREGS; r++) begin : g_reg
      assign col[k][r] = RegValues[r][k];
    end
    mux32_1 u_mux1 (.in_i(col[k]), .sel_i(ReadRegister1), .out_o(raw1[k]));
    mux32_1 u_mux2 (.in_i(col[k]), .sel_i(ReadRegister2), .out_o(raw2[k]));
  end

  always_comb begin
    byp1 = RegWrite && (WriteRegister == ReadRegister1) && (ReadRegister1 != ZERO_REG);
    byp2 = RegWrite && (WriteRegister == ReadRegister2) && (ReadRegister2 != ZERO_REG);
    nxt1 = (ReadRegister1 == ZERO_REG) ? '0 : (byp1 ? WriteData : raw1);
    nxt2 = (ReadRegister2 == ZERO_REG) ? '0 : (byp2 ? WriteData : raw2);
  end

  // Enable mux in front of the flops; Flush outranks Stall.
  always_comb begin
    rd1_d  = nxt1;
    rd2_d  = nxt2;
    idx1_d = ReadRegister1;
    idx2_d = ReadRegister2;
    vld_d  = ValidIn;
    if (Flush) begin
      rd1_d  = '0;
      rd2_d  = '0;
      idx1_d = '0;
      idx2_d = '0;
      vld_d  = 1'b0;
    end else if (Stall) begin
      rd1_d  = rd1_q;
      rd2_d  = rd2_q;
      idx1_d = idx1_q;
      idx2_d = idx2_q;
      vld_d  = vld_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rd1_q  <= '0;
      rd2_q  <= '0;
      idx1_q <= '0;
      idx2_q <= '0;
      vld_q  <= 1'b0;
    end else begin
      rd1_q  <= rd1_d;
      rd2_q  <= rd2_d;
      idx1_q <= idx1_d;
      idx2_q <= idx2_d;
      vld_q  <= vld_d;
    end
  end

  assign ReadData1 = rd1_q;
  assign ReadData2 = rd2_q;
  assign ReadReg1Q = idx1_q;
  assign ReadReg2Q = idx2_q;
  assign ValidOut  = vld_q;

endmodule

// File: tb/tb_regfile_read_port.sv
// Bench for regfile_read_port: directed cases then random traffic against a reference model.
module tb_regfile_read_port;

  logic              clk;
  logic              reset;
  logic [31:0][63:0] RegValues;
  logic [4:0]        ReadRegister1, ReadRegister2, WriteRegister;
  logic              ValidIn, RegWrite, Stall, Flush;
  logic [63:0]       WriteData;
  logic [63:0]       ReadData1, ReadData2;
  logic [4:0]        ReadReg1Q, ReadReg2Q;
  logic              ValidOut;

  int n_checks = 0;
  int n_fails  = 0;

  logic [63:0] e_rd1, e_rd2;
  logic [4:0]  e_i1, e_i2;
  logic        e_vld;

  regfile_read_port dut (
    .clk(clk), .reset(reset), .RegValues(RegValues),
    .ReadRegister1(ReadRegister1), .ReadRegister2(ReadRegister2),
    .ValidIn(ValidIn), .RegWrite(RegWrite), .WriteRegister(WriteRegister),
    .WriteData(WriteData), .Stall(Stall), .Flush(Flush),
    .ReadData1(ReadData1), .ReadData2(ReadData2),
    .ReadReg1Q(ReadReg1Q), .ReadReg2Q(ReadReg2Q), .ValidOut(ValidOut)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Operand the architecture defines for a read of register idx this cycle.
  function automatic logic [63:0] operand(input logic [4:0] idx);
    if (idx == 5'd31) return 64'h0;
    if (RegWrite && WriteRegister == idx) return WriteData;
    return RegValues[idx];
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance the model, clock the DUT, then compare every output against the model.
  task automatic tick(input string tag);
    if (reset || Flush) begin
      e_rd1 = 0; e_rd2 = 0; e_i1 = 0; e_i2 = 0; e_vld = 0;
    end else if (!Stall) begin
      e_rd1 = operand(ReadRegister1);
      e_rd2 = operand(ReadRegister2);
      e_i1  = ReadRegister1;
      e_i2  = ReadRegister2;
      e_vld = ValidIn;
    end
    @(posedge clk);
    #1;
    check({tag, ".rd1"}, ReadData1, e_rd1);
    check({tag, ".rd2"}, ReadData2, e_rd2);
    check({tag, ".idx1"}, {59'd0, ReadReg1Q}, {59'd0, e_i1});
    check({tag, ".idx2"}, {59'd0, ReadReg2Q}, {59'd0, e_i2});
    check({tag, ".vld"}, {63'd0, ValidOut}, {63'd0, e_vld});
  endtask

  initial begin
    reset = 0; Stall = 0; Flush = 0; ValidIn = 0; RegWrite = 0;
    WriteRegister = 0; WriteData = 0; ReadRegister1 = 0; ReadRegister2 = 0;
    for (int r = 0; r < 32; r++) RegValues[r] = {$urandom, $urandom};
    e_rd1 = 'x; e_rd2 = 'x; e_i1 = 'x; e_i2 = 'x; e_vld = 'x;
    @(posedge clk); #1;

    // Reset with live inputs
    reset = 1; ValidIn = 1; ReadRegister1 = 3; RegValues[3] = 64'hDEAD;
    tick("reset");
    check("reset.rd1_lit", ReadData1, 64'h0);
    check("reset.vld_lit", {63'd0, ValidOut}, 64'h0);
    reset = 0;

    // Plain read
    RegValues[5] = 64'h12345678_ABCDEF01; RegValues[9] = 64'hFFFF;
    ReadRegister1 = 5; ReadRegister2 = 9; ValidIn = 1;
    tick("plain");
    check("plain.rd1_lit", ReadData1, 64'h12345678_ABCDEF01);
    check("plain.rd2_lit", ReadData2, 64'hFFFF);
    check("plain.vld_lit", {63'd0, ValidOut}, 64'h1);

    // Bypass to both ports
    RegValues[7] = 64'h1; RegWrite = 1; WriteRegister = 7; WriteData = 64'hDEADBEEF_CAFEFADE;
    ReadRegister1 = 7; ReadRegister2 = 7;
    tick("bypass");
    check("bypass.rd1_lit", ReadData1, 64'hDEADBEEF_CAFEFADE);
    check("bypass.rd2_lit", ReadData2, 64'hDEADBEEF_CAFEFADE);

    // Zero register, without and with a write to X31
    RegWrite = 0; RegValues[31] = 64'hAAAA; ReadRegister1 = 31; ReadRegister2 = 9;
    tick("zero");
    check("zero.rd1_lit", ReadData1, 64'h0);
    RegWrite = 1; WriteRegister = 31; WriteData = 64'h5;
    tick("zero_wr");
    check("zero_wr.rd1_lit", ReadData1, 64'h0);
    RegWrite = 0;

    // Stall holds for three cycles, including across a write to the new source
    RegValues[2] = 64'h11; ReadRegister1 = 2;
    tick("stall_load");
    check("stall_load.rd1_lit", ReadData1, 64'h11);
    Stall = 1; ReadRegister1 = 4; RegValues[4] = 64'h22;
    for (int c = 0; c < 3; c++) begin
      if (c == 1) begin RegWrite = 1; WriteRegister = 2; WriteData = 64'h99; end
      else RegWrite = 0;
      tick("stall_hold");
      check("stall_hold.rd1_lit", ReadData1, 64'h11);
    end
    Stall = 0; RegWrite = 0;
    tick("stall_release");
    check("stall_release.rd1_lit", ReadData1, 64'h22);

    // Flush beats Stall
    Stall = 1; Flush = 1;
    tick("flush_stall");
    check("flush_stall.rd1_lit", ReadData1, 64'h0);
    check("flush_stall.vld_lit", {63'd0, ValidOut}, 64'h0);
    Stall = 0; Flush = 0;
    tick("refill");

    // Reset while stalled and flushed
    Stall = 1; Flush = 1; reset = 1;
    tick("reset_mid");
    reset = 0; Flush = 0; Stall = 0;

    // Random traffic
    for (int c = 0; c < 400; c++) begin
      if ($urandom_range(0, 3) == 0) RegValues[$urandom_range(0, 31)] = {$urandom, $urandom};
      ReadRegister1 = 5'($urandom_range(0, 31));
      ReadRegister2 = ($urandom_range(0, 4) == 0) ? ReadRegister1 : 5'($urandom_range(0, 31));
      ValidIn  = 1'($urandom_range(0, 1));
      RegWrite = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 3))
        0: WriteRegister = ReadRegister1;
        1: WriteRegister = ReadRegister2;
        2: WriteRegister = 5'd31;
        default: WriteRegister = 5'($urandom_range(0, 31));
      endcase
      WriteData = {$urandom, $urandom};
      Stall = ($urandom_range(0, 4) == 0);
      Flush = ($urandom_range(0, 9) == 0);
      reset = ($urandom_range(0, 39) == 0);
      tick("rand");
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/regfile_read_port.md
# regfile_read_port

Dual read port for the 32×64 ARM register file, on the consumer side of the register write path. It selects two 64-bit operands from the 32 stored registers and forwards a same-cycle write so the read sees the new value. X31 always reads as zero. Both operands land in a stallable, flushable pipeline register that feeds the execute stage one cycle later.

## Interface
Parameters:
- WIDTH, 64, data width of each register and operand
- NREGS, 32, number of architectural registers (index width 5)

Ports:
- clk  input  1  system clock; all state updates on rising edge
- reset  input  1  synchronous, active-high; clears all state on the next rising edge
- RegValues  input  32×64  current contents of every register (packed [31:0][63:0])
- ReadRegister1  input  5  index of operand A
- ReadRegister2  input  5  index of operand B
- ValidIn  input  1  decode stage presents a real instruction this cycle
- RegWrite  input  1  write port is committing this cycle
- WriteRegister  input  5  index being written this cycle
- WriteData  input  64  value being written this cycle
- Stall  input  1  hold the output pipeline register
- Flush  input  1  squash the output pipeline register
- ReadData1  output  64  registered operand A
- ReadData2  output  64  registered operand B
- ReadReg1Q  output  5  registered copy of ReadRegister1
- ReadReg2Q  output  5  registered copy of ReadRegister2
- ValidOut  output  1  registered ValidIn

## Operation
- Combinational select per port: raw = RegValues[ReadRegisterN].
- Bypass per port: if RegWrite and WriteRegister == ReadRegisterN and ReadRegisterN != 31, the next value is WriteData. Otherwise it is raw.
- Zero register: if ReadRegisterN == 31, the next value is 64'h0. This overrides both bypass and RegValues[31].
- Ports 1 and 2 are independent. Both may name the same register and both may bypass in the same cycle.
- Pipeline register update priority, highest first:
  - reset: all outputs become 0.
  - Flush: ReadData1/2 = 0, ReadReg1Q/2Q = 0, ValidOut = 0. Flush beats Stall.
  - Stall: all outputs hold.
  - Otherwise: load the next values, and ValidOut = ValidIn.
- Data is loaded whether or not ValidIn is set. Consumers qualify the data with ValidOut.
- No internal state besides the output register. There is no FSM.

## Timing
- Latency: 1 cycle from ReadRegisterN/ValidIn to ReadDataN/ValidOut.
- Bypass is evaluated in the same cycle as the write. A read that samples at the same edge as a write returns WriteData, not the stale RegValues.
- Reset values: ReadData1 = ReadData2 = 0, ReadReg1Q = ReadReg2Q = 0, ValidOut = 0.
- Reset mid-stall or mid-flush: reset wins. Outputs are 0 after that edge.
- Stall held for N cycles: outputs hold for N cycles. A write that occurs during a stall is not picked up into the held data. The held operand is stale by design and the hazard unit accounts for it.
- Stall and Flush together: Flush wins.
- RegWrite with WriteRegister == 31: never bypassed, and reads of 31 still return 0.

## Structure
- Shared package regfile_pkg:
  - constants WIDTH = 64, NREGS = 32, ZERO_REG = 5'd31
  - typedef reg_idx_t (logic [4:0])
  - typedef word_t (logic [63:0])
  - Both typedefs are shared with the write-side register file.
- Sub-module mux32_1: a 32:1 one-bit mux built from mux2_1 stages. The top level instantiates it 64 times per port through a generate loop.
- Bypass compare, zero-register override and the pipeline register (D_FF plus 2:1 enable mux, as in the write path) live in the top level.

## Test plan
- Reset: assert reset one cycle with ReadRegister1 = 3 and RegValues[3] = 64'hDEAD -> all outputs 0 and ValidOut = 0 after the edge.
- Plain read: RegValues[5] = 64'h12345678_ABCDEF01, RegValues[9] = 64'hFFFF, ReadRegister1 = 5, ReadRegister2 = 9, ValidIn = 1 -> next cycle ReadData1 = 64'h12345678_ABCDEF01, ReadData2 = 64'hFFFF, ValidOut = 1.
- Bypass: RegValues[7] = 64'h1, RegWrite = 1, WriteRegister = 7, WriteData = 64'hDEADBEEF_CAFEFADE, both ports read 7 -> both ReadData = 64'hDEADBEEF_CAFEFADE.
- Zero register:
  - RegValues[31] = 64'hAAAA, ReadRegister1 = 31 -> ReadData1 = 0.
  - Additionally with RegWrite = 1, WriteRegister = 31, WriteData = 64'h5 -> ReadData1 still 0.
- Stall: load 64'h11 from register 2, then hold Stall = 1 for 3 cycles while ReadRegister1 = 4 (RegValues[4] = 64'h22) -> ReadData1 stays 64'h11 for 3 cycles, then 64'h22 the cycle after Stall drops.
- Flush over Stall: with valid data held, assert Stall = 1 and Flush = 1 together -> next cycle ReadData1/2 = 0, ValidOut = 0.
